alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  bit i = requester i presents an operation.
REQ-005 req_ready  output  2  bit i = arbiter accepts requester i this cycle.
REQ-006 req_op0, req_op1  input  3 each  ALU operation code per requester.
REQ-007 req_a0, req_b0, req_a1, req_b1  input  WIDTH each  operands per requester.
REQ-008 rsp_valid  output  2  bit i = result for requester i is held on the outputs.
REQ-009 rsp_ready  input  2  bit i = requester i consumes its result.
REQ-010 rsp_result  output  WIDTH  result of the granted operation, shared by both requesters.
REQ-011 rsp_zero  output  1  high when rsp_result equals zero.
REQ-012 op_count  output  16  count of completed response handshakes.

Function
REQ-013 FSM states: IDLE, RESP; reset state IDLE.
REQ-014 In IDLE, req_ready SHALL equal the one-hot grant of the arbitration winner; req_ready SHALL be 0 in RESP.
REQ-015 Arbitration SHALL be round-robin: when both req_valid bits are set, the requester not granted last wins; last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-016 A single valid requester SHALL win regardless of the pointer; the pointer updates only on acceptance.
REQ-017 On acceptance (IDLE, req_valid[i] and req_ready[i]) the arbiter SHALL register the result and winner index and move to RESP; rsp_valid[i] rises the next cycle (latency 1).
REQ-018 Op codes: 000 AND, 001 OR, 010 add, 110 sub, 111 signed set-less-than (result 1 or 0); any other code SHALL yield result 0.
REQ-019 Add/sub SHALL wrap modulo 2^WIDTH with no overflow output.
REQ-020 In RESP, rsp_valid SHALL be one-hot for the winner, and rsp_result/rsp_zero SHALL remain stable until rsp_valid[i] and rsp_ready[i] are both high.
REQ-021 On the response handshake the FSM SHALL return to IDLE; a new acceptance occurs no earlier than the next cycle (max throughput one op per 2 cycles).
REQ-022 rsp_ready of the non-granted requester SHALL be ignored.
REQ-023 A req_valid deasserted without acceptance SHALL be treated as withdrawn; no state changes.
REQ-024 op_count SHALL increment by 1 per response handshake and saturate at 16'hFFFF.
REQ-025 In IDLE, rsp_valid SHALL be 0; rsp_result and rsp_zero hold their last values.

Reset
REQ-026 While rst_n is low at a rising edge: state IDLE, pointer 1, rsp_valid 0, rsp_result 0, rsp_zero 1, op_count 0.
REQ-027 Reset asserted in RESP SHALL discard the pending result without a handshake and leave op_count at 0.
REQ-028 req_ready SHALL be 0 during any cycle in which rst_n is low.

Configuration
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and the pointer is unused; when undefined, REQ-015 round-robin applies.

Verification
REQ-030 Reset, then req_valid=01, op0=010, a0=5, b0=7 -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_result=12, rsp_zero=0.
REQ-031 req_valid=11 held for two acceptances, both op=110, a=3, b=3 -> grants 01 then 10 (fixed-prio build: 01 then 01); rsp_result=0, rsp_zero=1 each time.
REQ-032 Accept op=111, a=32'hFFFFFFFF, b=1 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result=1 stable, req_ready=00 throughout; rsp_ready=1 -> IDLE next cycle, op_count=1.
REQ-033 Add 32'hFFFFFFFF + 1 -> rsp_result=0, rsp_zero=1; op=011 -> rsp_result=0.
REQ-034 rst_n low for one cycle while in RESP -> rsp_valid=00, op_count=0, pointer reset so next contention grants 01.
REQ-035 Preload op_count near 16'hFFFF via repeated handshakes -> op_count stops at 16'hFFFF.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// One ALU shared by two requesters. A two-state FSM (IDLE, RESP) accepts one
// operation per visit to IDLE, registers the result, and holds it on the
// shared response outputs until the winning requester takes it.
// Contention is resolved round-robin: the requester that was not granted last
// wins, and requester 0 wins the first contention after reset.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins contention
//                           and the round-robin pointer is not built.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid[1:0]        per-requester operation present
//   req_ready[1:0]        per-requester accept (one-hot grant, IDLE only)
//   req_op0/1[2:0]        op code per requester
//   req_a0/b0/a1/b1       operands per requester
//   rsp_valid[1:0]        one-hot: result for that requester is held
//   rsp_ready[1:0]        per-requester result consume
//   rsp_result[WIDTH-1:0] shared registered result
//   rsp_zero              rsp_result == 0
//   op_count[15:0]        saturating count of response handshakes
//
// Op codes: 000 AND, 001 OR, 010 add, 110 sub, 111 signed set-less-than,
// anything else gives 0. Add/sub wrap modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [15:0]      op_count
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state_q, state_d;
  logic             win_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [15:0]      count_q;

  logic [1:0]       grant;
  logic             win_idx;
  logic             accept;
  logic             handshake;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, alu_res;

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Index of the requester granted most recently; resets to 1 so that
  // requester 0 wins the first contention.
  logic last_q;
`endif

  // NOTE: every signal assigned in an always_comb gets a default on entry, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = last_q ? 2'b01 : 2'b10;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

  // Grant is a subset of req_valid, so any valid request in IDLE is accepted.
  assign accept    = (state_q == IDLE) && (|req_valid);
  assign win_idx   = grant[1];
  assign req_ready = (rst_n && (state_q == IDLE)) ? grant : 2'b00;

  assign sel_op  = win_idx ? req_op1 : req_op0;
  assign sel_a   = win_idx ? req_a1  : req_a0;
  assign sel_b   = win_idx ? req_b1  : req_b0;
  assign alu_res = alu(sel_op, sel_a, sel_b);

  // Only the winner's rsp_ready can complete the response.
  assign handshake = (state_q == RESP) && rsp_ready[win_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RESP;
      RESP:    if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      count_q  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_q    <= win_idx;
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_q   <= win_idx;
`endif
      end
      if (handshake && (count_q != 16'hFFFF)) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign rsp_valid  = (state_q == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Drives alu_share_arbiter with directed scenarios and randomized traffic.
// A transaction-level model (pending response + grant history + count) gives
// the expected outputs every cycle; literal expectations pin the model.
// Honours ALU_ARB_FIXED_PRIO_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2:0]       req_op0, req_op1;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic [15:0]      op_count;

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: at most one outstanding response, plus who was granted last.
  bit               m_busy;
  int               m_win;
  logic [WIDTH-1:0] m_res;
  int               m_last;
  int               m_cnt;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return WIDTH'((64'(a) + 64'(b)) % (64'd1 << WIDTH));
      3'd6:    return WIDTH'((64'(a) + (64'd1 << WIDTH) - 64'(b)) % (64'd1 << WIDTH));
      3'd7:    return (sa < sb) ? WIDTH'(1) : WIDTH'(0);
      default: return '0;
    endcase
  endfunction

  function automatic logic [1:0] exp_ready();
    if (!rst_n || m_busy) return 2'b00;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 2'b01;
`else
      return (m_last == 1) ? 2'b01 : 2'b10;
`endif
    end
    return req_valid;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_win = 0; m_res = '0; m_last = 1; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [1:0] g;
    g = exp_ready();
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      if (rsp_ready[m_win]) begin
        m_busy = 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (g != 2'b00) begin
      m_win  = (g == 2'b10) ? 1 : 0;
      m_res  = (m_win == 1) ? ref_alu(req_op1, req_a1, req_b1)
                            : ref_alu(req_op0, req_a0, req_b0);
      m_last = m_win;
      m_busy = 1;
    end
  endtask

  // One clock: compare all outputs against the model, advance the model,
  // and return at the next falling edge where inputs may change.
  task automatic tick();
    #1;
    check("req_ready", 64'(req_ready), 64'(exp_ready()));
    check("rsp_valid", 64'(rsp_valid), m_busy ? 64'(2'b01 << m_win) : 64'd0);
    check("rsp_result", 64'(rsp_result), 64'(m_res));
    check("rsp_zero", 64'(rsp_zero), 64'(m_res == '0));
    check("op_count", 64'(op_count), 64'(m_cnt));
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return WIDTH'($urandom_range(0, 8));
      default: return $urandom;
    endcase
  endfunction

  logic [1:0] exp_second;

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op0 = 3'd0; req_op1 = 3'd0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    model_reset();
    // Let the synchronous reset take hold before anything is compared.
    @(posedge clk); @(posedge clk); @(negedge clk);
    do_reset();

    // Reset state and a single add: 5 + 7 = 12 one cycle after acceptance.
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_zero", 64'(rsp_zero), 64'd1);
    check("reset_count", 64'(op_count), 64'd0);
    req_valid = 2'b01; req_op0 = 3'b010; req_a0 = 32'd5; req_b0 = 32'd7;
    #1 check("add_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    #1;
    check("add_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    check("add_result", 64'(rsp_result), 64'd12);
    check("add_zero", 64'(rsp_zero), 64'd0);
    rsp_ready = 2'b01;
    tick();

    // Contention: both subtract 3-3, grants alternate (or stay on 0).
    do_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_second = 2'b01;
`else
    exp_second = 2'b10;
`endif
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_op0 = 3'b110; req_a0 = 32'd3; req_b0 = 32'd3;
    req_op1 = 3'b110; req_a1 = 32'd3; req_b1 = 32'd3;
    #1 check("rr_grant1", 64'(req_ready), 64'(2'b01));
    tick();
    #1;
    check("rr_rsp1", 64'(rsp_valid), 64'(2'b01));
    check("rr_zero1", 64'(rsp_zero), 64'd1);
    check("rr_busy_ready", 64'(req_ready), 64'd0);
    tick();
    #1 check("rr_grant2", 64'(req_ready), 64'(exp_second));
    tick();
    #1;
    check("rr_rsp2", 64'(rsp_valid), 64'(exp_second));
    check("rr_res2", 64'(rsp_result), 64'd0);
    tick();

    // Signed -1 < 1 held for five cycles, then consumed.
    do_reset();
    req_valid = 2'b01; req_op0 = 3'b111; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1;
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_valid", 64'(rsp_valid), 64'(2'b01));
      check("hold_result", 64'(rsp_result), 64'd1);
      check("hold_ready", 64'(req_ready), 64'd0);
      req_valid = (i % 2 == 0) ? 2'b11 : 2'b00;
      rsp_ready = 2'b10;  // non-granted requester's ready is ignored
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    tick();
    #1;
    check("hold_done_valid", 64'(rsp_valid), 64'd0);
    check("hold_count", 64'(op_count), 64'd1);

    // Add wrap and an undefined op code.
    req_valid = 2'b01; req_op0 = 3'b010; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1;
    rsp_ready = 2'b01;
    tick();
    #1;
    check("wrap_result", 64'(rsp_result), 64'd0);
    check("wrap_zero", 64'(rsp_zero), 64'd1);
    tick();
    req_op0 = 3'b011; req_a0 = 32'd5; req_b0 = 32'd9;
    tick();
    #1 check("badop_result", 64'(rsp_result), 64'd0);
    tick();

    // Reset while a response is pending.
    req_valid = 2'b10; req_op1 = 3'b001; req_a1 = 32'h10; req_b1 = 32'h01;
    rsp_ready = 2'b00;
    tick();
    rst_n = 1'b0; req_valid = 2'b11;
    #1 check("rst_ready", 64'(req_ready), 64'd0);
    tick();
    rst_n = 1'b1; req_valid = 2'b00;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_count", 64'(op_count), 64'd0);
    req_valid = 2'b11;
    #1 check("rst_grant", 64'(req_ready), 64'(2'b01));
    tick();
    rsp_ready = 2'b11;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      req_op0   = 3'($urandom);
      req_op1   = 3'($urandom);
      req_a0 = rand_word(); req_b0 = rand_word();
      req_a1 = rand_word(); req_b1 = rand_word();
      tick();
    end

    // Saturation: start the counter just below full and keep handshaking.
    rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    tick();
    tick();
    force dut.count_q = 16'hFFFC;
    #1;
    release dut.count_q;
    m_cnt = 16'hFFFC;
    req_valid = 2'b01; rsp_ready = 2'b11; req_op0 = 3'b001;
    for (int i = 0; i < 12; i++) tick();
    #1 check("sat_count", 64'(op_count), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
